// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for the shared 4-bit add/sub units.
// It also contains a private shift-add multiplier; results return tagged with the requester id.
module alu_req_arbiter #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [1:0]     req0_op,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [1:0]     req1_op,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   output logic           add_en,
   output logic           sub_en,
   output logic [W-1:0]   unit_a,
   output logic [W-1:0]   unit_b,
   input  logic [2*W-1:0] add_out,
   input  logic [2*W-1:0] sub_out,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [2*W-1:0] res_data,
   output logic           res_id,
   output logic           res_err
);
   localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2, DONE = 2'd3;
   localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10;
   localparam int CW = $clog2(W + 1);

   logic [1:0]     state;
   logic           ptr;
   logic           grant0, grant1, accept, win_id;
   logic [1:0]     op_r, win_op;
   logic [W-1:0]   a_r, b_r, win_a, win_b, mplier;
   logic [2*W-1:0] acc, mcand, acc_next;
   logic [CW-1:0]  cnt;

   // ptr=0 favours requester 0 when both are valid
   assign grant0     = req0_valid & (~req1_valid | ~ptr);
   assign grant1     = req1_valid & (~req0_valid | ptr);
   assign req0_ready = (state == IDLE) & ~rst & grant0;
   assign req1_ready = (state == IDLE) & ~rst & grant1;
   assign accept     = req0_ready | req1_ready;
   assign win_id     = req1_ready;
   assign win_op     = win_id ? req1_op : req0_op;
   assign win_a      = win_id ? req1_a  : req0_a;
   assign win_b      = win_id ? req1_b  : req0_b;

   // Shared unit buses are only driven during the single EXEC cycle
   assign add_en    = (state == EXEC) & (op_r == OP_ADD);
   assign sub_en    = (state == EXEC) & (op_r == OP_SUB);
   assign unit_a    = (state == EXEC) ? a_r : '0;
   assign unit_b    = (state == EXEC) ? b_r : '0;
   assign res_valid = (state == DONE);

   assign acc_next = acc + (mplier[0] ? mcand : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= 1'b0;
         res_data <= '0;
         res_id   <= 1'b0;
         res_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_r    <= win_op;
                  a_r     <= win_a;
                  b_r     <= win_b;
                  res_id  <= win_id;
                  res_err <= 1'b0;
                  ptr     <= ~win_id;
                  case (win_op)
                     OP_ADD, OP_SUB: state <= EXEC;
                     OP_MUL: begin
                        state  <= MUL;
                        acc    <= '0;
                        mcand  <= {{W{1'b0}}, win_a};
                        mplier <= win_b;
                        cnt    <= '0;
                     end
                     default: begin
                        state    <= DONE;
                        res_data <= '0;
                        res_err  <= 1'b1;
                     end
                  endcase
               end
            end
            EXEC: begin
               res_data <= (op_r == OP_SUB) ? sub_out : add_out;
               state    <= DONE;
            end
            MUL: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(W - 1)) begin
                  res_data <= acc_next;
                  state    <= DONE;
               end
            end
            default: begin
               if (res_ready) state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: stimulus pushes expected results, a monitor pops and compares.
// The bench also models the shared adder and subtractor on the unit buses.
module tb_alu_req_arbiter;
   localparam int W = 4;
   localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_ILL = 2'b11;

   logic           clk = 1'b0;
   logic           rst;
   logic           req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0]     req0_op, req1_op;
   logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
   logic           add_en, sub_en;
   logic [W-1:0]   unit_a, unit_b;
   logic [2*W-1:0] add_out, sub_out;
   logic           res_valid, res_ready;
   logic [2*W-1:0] res_data;
   logic           res_id, res_err;

   logic [9:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign add_out = {4'b0, unit_a} + {4'b0, unit_b};
   assign sub_out = {4'b0, unit_a} - {4'b0, unit_b};

   alu_req_arbiter #(.W(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .add_en(add_en), .sub_en(sub_en), .unit_a(unit_a), .unit_b(unit_b),
      .add_out(add_out), .sub_out(sub_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_id(res_id), .res_err(res_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {9'b0, req0_ready, req1_ready, add_en, sub_en, unit_a, unit_b,
              res_valid, res_data, res_id, res_err};
   endfunction

   // Scoreboard monitor: samples mid-cycle, after stimulus has settled
   always @(negedge clk) begin
      logic [9:0] e;
      #2;
      if (!rst) begin
         if (req0_ready || req1_ready) chk("one_ready", {31'b0, req0_ready & req1_ready}, 0);
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_result: got id=%0d err=%0d data=%0h, none expected",
                        res_id, res_err, res_data);
            end else begin
               e = exp_q.pop_front();
               chk("result", {22'b0, res_id, res_err, res_data}, {22'b0, e});
            end
         end
      end
   end

   task automatic do_op(input string nm, input bit id, input logic [1:0] op,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp_d, input bit exp_e, input int lat);
      bit got = 0;
      @(negedge clk);
      if (!id) begin
         req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
      end
      #1;
      for (int w = 0; w < 20; w++) begin
         if (id ? req1_ready : req0_ready) begin
            got = 1;
            break;
         end
         @(negedge clk); #1;
      end
      chk({nm, "_ready"}, {31'b0, got}, 1);
      chk({nm, "_other_ready"}, {31'b0, id ? req0_ready : req1_ready}, 0);
      exp_q.push_back({id, exp_e, exp_d});
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         req0_valid = 0; req1_valid = 0;
         #1;
         chk({nm, "_res_valid"}, {31'b0, res_valid}, {31'b0, k == lat});
         if (op == OP_ADD && k == 1)
            chk({nm, "_units"}, {22'b0, add_en, sub_en, unit_a, unit_b}, {22'b0, 2'b10, a, b});
         else if (op == OP_SUB && k == 1)
            chk({nm, "_units"}, {22'b0, add_en, sub_en, unit_a, unit_b}, {22'b0, 2'b01, a, b});
         else
            chk({nm, "_units_idle"}, {22'b0, add_en, sub_en, unit_a, unit_b}, 0);
      end
   endtask

   task automatic drain(input string nm);
      for (int c = 0; c < 50; c++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      chk({nm, "_drain"}, exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      bit seen;
      rst = 1; res_ready = 1;
      req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      #1;
      chk("reset_outputs", all_outs(), 0);

      // Basic ADD, SUB, MUL
      do_op("add", 0, OP_ADD, 4'd7, 4'd9, 8'h10, 0, 2);
      do_op("sub", 1, OP_SUB, 4'd3, 4'd5, 8'hFE, 0, 2);
      do_op("mul", 0, OP_MUL, 4'd15, 4'd15, 8'hE1, 0, 5);
      drain("basic");

      // Fresh pointer, then both requesters held valid
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
      #1;
      chk("rst_pulse_outputs", all_outs(), 0);
      @(negedge clk);
      req0_op = OP_ADD; req0_a = 4'd1; req0_b = 4'd2;
      req1_op = OP_ADD; req1_a = 4'd4; req1_b = 4'd8;
      req0_valid = 1; req1_valid = 1;
      n = 0;
      for (int c = 0; c < 60 && n < 4; c++) begin
         #1;
         if (req0_ready || req1_ready) begin
            chk("rr_grant", {31'b0, req1_ready}, n % 2);
            if (req1_ready) exp_q.push_back({1'b1, 1'b0, 8'h0C});
            else            exp_q.push_back({1'b0, 1'b0, 8'h03});
            n++;
         end
         @(negedge clk);
      end
      req0_valid = 0; req1_valid = 0;
      chk("rr_count", n, 4);
      drain("rr");

      // Back-pressure in DONE
      res_ready = 0;
      do_op("hold", 1, OP_SUB, 4'd9, 4'd2, 8'h07, 0, 2);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         req0_valid = 1; req0_op = OP_ADD; req0_a = 4'd1; req0_b = 4'd1;
         #1;
         chk("hold_valid", {31'b0, res_valid}, 1);
         chk("hold_data", {24'b0, res_data}, 32'h07);
         chk("hold_no_ready", {30'b0, req0_ready, req1_ready}, 0);
      end
      @(negedge clk);
      req0_valid = 0; res_ready = 1;
      drain("hold");

      do_op("illegal", 0, OP_ILL, 4'd5, 4'd6, 8'h00, 1, 1);
      drain("illegal");

      // Reset during the second MUL cycle drops the op
      @(negedge clk);
      req0_valid = 1; req0_op = OP_MUL; req0_a = 4'd3; req0_b = 4'd3;
      #1;
      chk("mul_rst_ready", {31'b0, req0_ready}, 1);
      @(negedge clk); req0_valid = 0;
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
      #1;
      chk("mul_rst_outputs", all_outs(), 0);
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk); #1;
         if (res_valid) seen = 1;
      end
      chk("mul_rst_no_result", {31'b0, seen}, 0);

      @(negedge clk);
      req0_op = OP_ADD; req0_a = 4'd2; req0_b = 4'd3;
      req1_op = OP_SUB; req1_a = 4'd8; req1_b = 4'd1;
      req0_valid = 1; req1_valid = 1;
      #1;
      chk("post_rst_grant", {30'b0, req0_ready, req1_ready}, 32'b10);
      exp_q.push_back({1'b0, 1'b0, 8'h05});
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      drain("post_rst");

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Round-robin controller that shares the 4-bit arithmetic units (adder, subtractor) between two requesters. It also provides an internal shift-add multiplier. It captures one operation per handshake, drives the shared units' enable and operand buses, collects the 8-bit result, and returns it tagged with the requester id. It sits between the input/keypad front-ends and the combinational add/sub units of the calculator datapath.

Parameters:
W, 4, operand width; result width is 2*W

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 illegal
req0_a  in  W  operand A
req0_b  in  W  operand B
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
add_en  out  1  enable to shared adder
sub_en  out  1  enable to shared subtractor
unit_a  out  W  operand A bus to shared units
unit_b  out  W  operand B bus to shared units
add_out  in  2*W  adder result (combinational)
sub_out  in  2*W  subtractor result (combinational)
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  2*W  result
res_id  out  1  id of the requester that issued the op
res_err  out  1  op was illegal

Behaviour:
- Single clock domain: clk. rst is synchronous and active-high.
- Reset state:
  - State IDLE; priority pointer favours req0.
  - All outputs 0: ready, en, unit buses, res_valid, res_data, res_id, res_err.
- rst at any point, including mid-EXEC/MUL/DONE: the op in flight is dropped and no result is produced. Outputs are 0 from the cycle after the reset edge.
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE:
  - If either valid is high, the arbiter picks a winner. reqN_ready = (state==IDLE) & grantN, combinational on valid.
  - The handshake completes on valid&ready. op/a/b are captured into registers at that edge.
  - Next state: ADD/SUB -> EXEC, MUL -> MUL, 11 -> DONE with res_data=0, res_err=1.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the pointer requester wins. The pointer then moves to the other id.
  - The pointer updates only on an accepted handshake.
- Requester obligation: requesters hold valid/op/a/b stable until ready. The block never asserts ready outside IDLE.
- EXEC (exactly 1 cycle):
  - Assert add_en (ADD) or sub_en (SUB), never both. unit_a/unit_b carry the captured operands.
  - At the end of the cycle, sample add_out or sub_out unmodified into res_data. Next state DONE.
- unit_a/unit_b/add_en/sub_en are 0 in every state other than EXEC.
- MUL (exactly W cycles):
  - Internal shift-add: acc (2W) += mcand when mplier LSB=1; mcand shifts left 1; mplier shifts right 1.
  - After W cycles, res_data = acc (unsigned, cannot overflow 2W). Next state DONE.
  - Shared units are not touched.
- DONE:
  - res_valid=1; res_data/res_id/res_err held stable.
  - On res_valid&res_ready: res_valid drops the next cycle and state returns to IDLE. A new request can be accepted in that IDLE cycle.
  - res_err is 0 for legal ops.
- Latency, accept edge at cycle T: ADD/SUB res_valid at T+2; MUL at T+1+W; illegal at T+1.
- Throughput: one op in flight at most. No backlog beyond the requesters' own valid hold.

Test Plan:
1. After reset, req0 ADD a=7 b=9 with a bench adder model. Required: req0_ready in the accept cycle; add_en=1, unit_a=7, unit_b=9 for exactly 1 cycle; res_valid 2 cycles after accept with res_data=0x10, res_id=0, res_err=0.
2. req1 SUB a=3 b=5 with a bench 8-bit two's-complement subtractor model. Required: sub_en high for exactly 1 cycle, add_en stays 0, res_data=0xFE, res_id=1.
3. req0 MUL a=15 b=15. Required: res_data=0xE1 five cycles after accept (W=4); add_en/sub_en stay 0 throughout.
4. req0_valid and req1_valid held high continuously with res_ready=1. Required: grants alternate 0,1,0,1 starting with 0; res_id follows the same sequence; never two readies in one cycle.
5. res_ready held low for 5 cycles in DONE. Required: res_valid/res_data stable and no ready asserted. Separately, op=11 yields res_data=0, res_err=1 one cycle after accept.
6. rst pulsed during the 2nd MUL cycle. Required: next cycle all outputs 0 and res_valid never rises for that op. Then both requesters valid: req0 is granted first.
